// File: rtl/ac_pkg.sv
// Shared definitions for the AC key conditioner: step FSM state type,
// key polarity and default 50 MHz timing constants.
package ac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_STB,
    ST_GAP,
    ST_HOLD,
    ST_LOCK
  } step_state_t;

  // Board push-buttons pull the line low when pressed.
  localparam logic KEY_ACTIVE_LOW = 1'b1;

  localparam int DEF_DEBOUNCE_CYC   = 1_000_000;   // 20 ms
  localparam int DEF_REPEAT_DLY_CYC = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_PER_CYC = 10_000_000;  // 200 ms
  localparam int DEF_STB_CYC        = 4;

endpackage

// File: rtl/ac_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   key_raw_i   raw key line (asynchronous, KEY_ACTIVE_LOW polarity)
//   held_o      debounced key state, 1 = pressed
//   press_o     one-cycle pulse in the cycle held_o rises
module ac_debounce
  import ac_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic held_o,
  output logic press_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          pressed;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;

  // Polarity is resolved after the synchroniser so nothing but a wire
  // sits in front of the first flop.
  assign pressed = sync2_q ^ KEY_ACTIVE_LOW;

  // Count consecutive cycles that disagree with the accepted state; any
  // agreeing sample (a bounce) restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (pressed == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = ~stable_q;
      press_d  = ~stable_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= KEY_ACTIVE_LOW;
      sync2_q  <= KEY_ACTIVE_LOW;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign held_o  = stable_q;
  assign press_o = press_q;

endmodule

// File: rtl/ac_key_conditioner.sv
// Front end of the AC setpoint/display stage: debounces the four board keys,
// turns up/down into framed step strobes with hold-to-repeat, toggles power
// and passes the timer key through as a level.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   key_up_n/key_dn_n          raw up/down keys, active-low
//   key_pwr_n/key_tmr_n        raw power/timer keys, active-low
//   step_stb                   high STB_CYC cycles per step
//   up_req/dn_req              direction level, one cycle before to one after step_stb
//   pwr_on                     power state, toggles per accepted power press
//   tmr_req                    debounced timer key level
module ac_key_conditioner
  import ac_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DLY_CYC = DEF_REPEAT_DLY_CYC,
  parameter int REPEAT_PER_CYC = DEF_REPEAT_PER_CYC,
  parameter int STB_CYC        = DEF_STB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_up_n,
  input  logic key_dn_n,
  input  logic key_pwr_n,
  input  logic key_tmr_n,
  output logic step_stb,
  output logic up_req,
  output logic dn_req,
  output logic pwr_on,
  output logic tmr_req
);

  // REPEAT_PER_CYC is expected not to exceed REPEAT_DLY_CYC, so both
  // thresholds fit the repeat counter.
  localparam int            RW        = $clog2(REPEAT_DLY_CYC + 1);
  localparam int            SW        = $clog2(STB_CYC + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DLY_CYC - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PER_CYC - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STB_CYC - 1);

  logic up_held, dn_held, tmr_held;
  logic up_press, dn_press, pwr_press;
  logic pwr_held_unused, tmr_press_unused;

  ac_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk(clk), .rst_n(rst_n), .key_raw_i(key_up_n), .held_o(up_held), .press_o(up_press)
  );
  ac_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .key_raw_i(key_dn_n), .held_o(dn_held), .press_o(dn_press)
  );
  ac_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pwr (
    .clk(clk), .rst_n(rst_n), .key_raw_i(key_pwr_n), .held_o(pwr_held_unused), .press_o(pwr_press)
  );
  ac_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_tmr (
    .clk(clk), .rst_n(rst_n), .key_raw_i(key_tmr_n), .held_o(tmr_held), .press_o(tmr_press_unused)
  );

  step_state_t   state_q;
  logic          dir_up_q;   // direction of the sequence in progress
  logic          rep_q;      // first auto-repeat already issued
  logic [RW-1:0] rpt_q;
  logic [SW-1:0] stb_cnt_q;
  logic          own_held, oth_held, rpt_due;

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v == '1) ? v : v + RW'(1);
  endfunction

  assign own_held = dir_up_q ? up_held : dn_held;
  assign oth_held = dir_up_q ? dn_held : up_held;
  // rpt_q counts from the accepted press for the first repeat and from
  // the previous ARM afterwards.
  assign rpt_due  = rpt_q >= (rep_q ? RPT_NEXT : RPT_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dir_up_q  <= 1'b0;
      rep_q     <= 1'b0;
      rpt_q     <= '0;
      stb_cnt_q <= '0;
      step_stb  <= 1'b0;
      up_req    <= 1'b0;
      dn_req    <= 1'b0;
    end else begin
      rpt_q <= sat_inc(rpt_q);
      case (state_q)
        ST_IDLE: begin
          rpt_q <= '0;
          rep_q <= 1'b0;
          if (up_held && dn_held) begin
            state_q <= ST_LOCK;
          end else if ((up_press && !dn_held) || (dn_press && !up_held)) begin
            // The press was accepted last cycle, so the timer starts at 1.
            state_q  <= ST_ARM;
            dir_up_q <= up_press;
            up_req   <= up_press;
            dn_req   <= ~up_press;
            rpt_q    <= RW'(1);
          end
        end
        ST_ARM: begin
          state_q   <= ST_STB;
          step_stb  <= 1'b1;
          stb_cnt_q <= '0;
        end
        ST_STB: begin
          if (stb_cnt_q == STB_LAST) begin
            state_q  <= ST_GAP;
            step_stb <= 1'b0;
          end else begin
            stb_cnt_q <= stb_cnt_q + SW'(1);
          end
        end
        ST_GAP: begin
          up_req <= 1'b0;
          dn_req <= 1'b0;
          if (oth_held)      state_q <= ST_LOCK;
          else if (own_held) state_q <= ST_HOLD;
          else               state_q <= ST_IDLE;
        end
        ST_HOLD: begin
          if (oth_held) begin
            state_q <= ST_LOCK;
          end else if (!own_held) begin
            state_q <= ST_IDLE;
          end else if (rpt_due) begin
            state_q <= ST_ARM;
            rep_q   <= 1'b1;
            rpt_q   <= '0;
            up_req  <= dir_up_q;
            dn_req  <= ~dir_up_q;
          end
        end
        ST_LOCK: begin
          if (!up_held && !dn_held) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_on  <= 1'b0;
      tmr_req <= 1'b0;
    end else begin
      pwr_on  <= pwr_on ^ pwr_press;
      tmr_req <= tmr_held;
    end
  end

endmodule

// File: tb/tb_ac_key_conditioner.sv
// Scoreboard bench for ac_key_conditioner. Each scenario is a per-cycle key
// trace; a reference model derives the expected step, power and timer events
// from the trace and queues them before the trace is driven. A monitor pops
// and compares whenever an output changes.
module tb_ac_key_conditioner;

  localparam int D   = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
  localparam int STB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_up_n = 1'b1, key_dn_n = 1'b1, key_pwr_n = 1'b1, key_tmr_n = 1'b1;
  logic step_stb, up_req, dn_req, pwr_on, tmr_req;

  ac_key_conditioner #(
    .DEBOUNCE_CYC(D), .REPEAT_DLY_CYC(DLY), .REPEAT_PER_CYC(PER), .STB_CYC(STB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_up_n(key_up_n), .key_dn_n(key_dn_n), .key_pwr_n(key_pwr_n), .key_tmr_n(key_tmr_n),
    .step_stb(step_stb), .up_req(up_req), .dn_req(dn_req), .pwr_on(pwr_on), .tmr_req(tmr_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; int v;} evt_t;
  evt_t q_req[$];
  evt_t q_pwr[$];
  evt_t q_tmr[$];

  int n_chk = 0;
  int n_err = 0;
  int pwr_m = 0;
  bit mon_en = 1'b0;

  // Trace bits: 0 up, 1 down, 2 power, 3 timer; 1 = pressed.
  logic [3:0] tr[$];

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexp(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s unexpected event at cycle %0d, required none", nm, cyc);
  endfunction

  task automatic add(input logic [3:0] v, input int n);
    repeat (n) tr.push_back(v);
  endtask

  function automatic int rawp(input int k, input int key);
    if (k < 0) return 0;
    return int'(tr[k][key]);
  endfunction

  task automatic push_evt(input int kind, input int t, input int v);
    evt_t e;
    e.t = t;
    e.v = v;
    if (kind == 0) q_req.push_back(e);
    else if (kind == 1) q_pwr.push_back(e);
    else q_tmr.push_back(e);
  endtask

  // Reference model. A key is accepted once its raw level has disagreed
  // with the accepted level for D straight samples; two synchroniser cycles
  // plus the counter put the acceptance D+2 cycles after the raw edge.
  // Steps are scheduled as ARM times: ARM, STB cycles of strobe, one GAP.
  task automatic model(input int B);
    int n, t, mode, dir, fire, a, g;
    bit all_diff, launch;
    logic [3:0] h;
    logic [3:0] held[];
    logic [3:0] pr[];
    n = tr.size();
    held = new[n];
    pr = new[n];
    h = '0;
    for (int i = 0; i < n; i++) begin
      pr[i] = '0;
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int j = i - D - 2; j <= i - 3; j++)
          if (rawp(j, k) == int'(h[k])) all_diff = 1'b0;
        if (all_diff) begin
          h[k] = ~h[k];
          pr[i][k] = h[k];
        end
      end
      held[i] = h;
    end
    for (int i = 0; i < n; i++) begin
      if (pr[i][2]) begin
        pwr_m ^= 1;
        push_evt(1, B + i + 1, pwr_m);
      end
      if (held[i][3] != ((i == 0) ? 1'b0 : held[i-1][3]))
        push_evt(2, B + i + 1, int'(held[i][3]));
    end
    // mode: 0 idle, 1 holding one key, 2 locked out
    t = 0;
    mode = 0;
    dir = 0;
    fire = 0;
    while (t < n) begin
      launch = 1'b0;
      if (mode == 0) begin
        if (held[t][0] && held[t][1]) begin
          mode = 2;
          t++;
        end else if ((pr[t][0] && !held[t][1]) || (pr[t][1] && !held[t][0])) begin
          dir = pr[t][0] ? 0 : 1;
          fire = t + DLY;
          launch = 1'b1;
        end else begin
          t++;
        end
      end else if (mode == 1) begin
        if (held[t][1-dir]) begin
          mode = 2;
          t++;
        end else if (!held[t][dir]) begin
          mode = 0;
          t++;
        end else if (t + 1 >= fire) begin
          fire = t + 1 + PER;
          launch = 1'b1;
        end else begin
          t++;
        end
      end else begin
        if (!held[t][0] && !held[t][1]) mode = 0;
        t++;
      end
      if (launch) begin
        a = t + 1;
        push_evt(0, B + a, dir);
        g = a + STB + 1;
        if (g >= n) begin
          t = n;
        end else begin
          mode = held[g][1-dir] ? 2 : (held[g][dir] ? 1 : 0);
          t = g + 1;
        end
      end
    end
  endtask

  task automatic drive(input logic [3:0] v);
    key_up_n  = ~v[0];
    key_dn_n  = ~v[1];
    key_pwr_n = ~v[2];
    key_tmr_n = ~v[3];
  endtask

  // Called 1 time unit after a rising edge; trace[k] is present during
  // cycle B+k.
  task automatic run();
    int B;
    B = cyc;
    model(B);
    for (int k = 0; k < tr.size(); k++) begin
      drive(tr[k]);
      @(posedge clk);
      #1;
    end
    tr.delete();
  endtask

  task automatic rand_scn();
    logic [3:0] v;
    int segs;
    segs = $urandom_range(3, 7);
    for (int s = 0; s < segs; s++) begin
      v = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = 4'b0000;
      if ($urandom_range(0, 3) == 0)
        for (int b = 0; b < int'($urandom_range(2, 8)); b++) tr.push_back(4'($urandom));
      add(v, $urandom_range(1, 40));
    end
    add(4'b0000, 40);
  endtask

  // Monitor
  initial begin
    logic pu, pd, ps, pp, pt;
    int req_t, stb_t;
    evt_t e;
    pu = 1'b0; pd = 1'b0; ps = 1'b0; pp = 1'b0; pt = 1'b0;
    req_t = -100;
    stb_t = -100;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("req_exclusive", int'(up_req & dn_req), 0);
        if (step_stb) chk("stb_framed", int'(up_req | dn_req), 1);
        if (up_req && !pu) begin
          if (q_req.size() == 0) unexp("up_req");
          else begin
            e = q_req.pop_front();
            chk("up_req_time", cyc, e.t);
            chk("up_req_dir", 0, e.v);
          end
          req_t = cyc;
        end
        if (dn_req && !pd) begin
          if (q_req.size() == 0) unexp("dn_req");
          else begin
            e = q_req.pop_front();
            chk("dn_req_time", cyc, e.t);
            chk("dn_req_dir", 1, e.v);
          end
          req_t = cyc;
        end
        if ((!up_req && pu) || (!dn_req && pd)) chk("req_width", cyc - req_t, STB + 2);
        if (step_stb && !ps) begin
          chk("stb_start", cyc - req_t, 1);
          stb_t = cyc;
        end
        if (!step_stb && ps) chk("stb_width", cyc - stb_t, STB);
        if (pwr_on != pp) begin
          if (q_pwr.size() == 0) unexp("pwr_on");
          else begin
            e = q_pwr.pop_front();
            chk("pwr_time", cyc, e.t);
            chk("pwr_val", int'(pwr_on), e.v);
          end
        end
        if (tmr_req != pt) begin
          if (q_tmr.size() == 0) unexp("tmr_req");
          else begin
            e = q_tmr.pop_front();
            chk("tmr_time", cyc, e.t);
            chk("tmr_val", int'(tmr_req), e.v);
          end
        end
      end
      pu = up_req; pd = dn_req; ps = step_stb; pp = pwr_on; pt = tmr_req;
    end
  end

  // Stimulus
  initial begin
    drive(4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step_stb", int'(step_stb), 0);
    chk("rst_up_req", int'(up_req), 0);
    chk("rst_dn_req", int'(dn_req), 0);
    chk("rst_pwr_on", int'(pwr_on), 0);
    chk("rst_tmr_req", int'(tmr_req), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Clean up press held 12 cycles: one step.
    add(4'b0001, 12); add(4'b0000, 40); run();
    // Up line toggling every 2 cycles: never accepted.
    repeat (8) begin add(4'b0001, 2); add(4'b0000, 2); end
    add(4'b0000, 40); run();
    // Down held long enough for ARMs at 7, 26, 34, 42, 50 and 58.
    add(4'b0010, 58); add(4'b0000, 40); run();
    // Up held, down joins at 10, both released at 40: lockout.
    add(4'b0001, 10); add(4'b0011, 30); add(4'b0000, 40); run();
    // Power press, release, press, with the timer key held meanwhile.
    add(4'b1100, 10); add(4'b1000, 5); add(4'b0000, 5); add(4'b0100, 10);
    add(4'b0000, 40); run();

    repeat (30) begin
      rand_scn();
      run();
    end

    // Reset during the first strobe, with power pressed alongside so
    // pwr_on is 1 when reset hits.
    mon_en = 1'b0;
    drive(4'b0101);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_up_req", int'(up_req), 1);
    chk("pre_rst_pwr_on", int'(pwr_on), pwr_m ^ 1);
    @(posedge clk);
    #1;
    chk("pre_rst_step_stb", int'(step_stb), 1);
    #2;
    rst_n = 1'b0;
    drive(4'b0001);
    #1;
    chk("mid_rst_step_stb", int'(step_stb), 0);
    chk("mid_rst_up_req", int'(up_req), 0);
    chk("mid_rst_pwr_on", int'(pwr_on), 0);
    pwr_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    // Up still held through reset release: a fresh step 7 cycles later.
    add(4'b0001, 20); add(4'b0000, 40); run();

    repeat (3) @(posedge clk);
    #1;
    chk("req_events_left", q_req.size(), 0);
    chk("pwr_events_left", q_pwr.size(), 0);
    chk("tmr_events_left", q_tmr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
